// File: rtl/bram_pingpong_scheduler.sv
// Streams a two-bank (ping-pong) sample BRAM out over AXI-Stream in strict bank order.
// BRAM read latency is absorbed by a small output FIFO that issues reads only when it has credit.
module bram_pingpong_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   frame_len,
    input  logic [1:0]            bank_full_set,
    output logic [1:0]            bank_free,
    output logic                  bram_en,
    output logic                  bram_bank_sel,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  overflow_err
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [1:0]              bank_full_q, bank_full_d;
    logic                    overflow_q, overflow_d;
    logic [1:0]              bank_free_q, bank_free_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    bank_sel_q, bank_sel_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0]   last_pipe_q, last_pipe_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic [CW-1:0]           outstanding_s;
    logic [CW:0]             occ_s;
    logic                    bram_en_s;
    logic                    final_addr_s;
    logic                    tvalid_s;
    logic                    tlast_s;
    logic                    push_s;
    logic                    pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Read credit, FIFO handshakes, latency pipeline and bank flags.
    always_comb begin
        outstanding_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding_s = outstanding_s + CW'(vld_pipe_q[i]);
        end
        occ_s        = {1'b0, count_q} + {1'b0, outstanding_s};
        final_addr_s = ({1'b0, addr_q} == (len_q - (ADDR_WIDTH + 1)'(1)));
        bram_en_s    = (state_q == ST_READ) && (occ_s < (CW + 1)'(FIFO_DEPTH));
        tvalid_s     = (count_q != '0);
        tlast_s      = tvalid_s & fifo_last_q[rd_ptr_q];
        push_s       = vld_pipe_q[RD_LATENCY-1];
        pop_s        = tvalid_s & m_axis_tready;

        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = bram_en_s;
        last_pipe_d[0] = bram_en_s & final_addr_s;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = bram_rdata;
            fifo_last_d[wr_ptr_q] = last_pipe_q[RD_LATENCY-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A set coinciding with the free pulse of the same bank wins silently.
        bank_full_d = bank_full_q;
        for (int b = 0; b < 2; b++) begin
            if (bank_full_set[b]) begin
                bank_full_d[b] = 1'b1;
            end else if (bank_free_q[b]) begin
                bank_full_d[b] = 1'b0;
            end else begin
                bank_full_d[b] = bank_full_q[b];
            end
        end
        overflow_d = overflow_q | (|(bank_full_set & bank_full_q & ~bank_free_q));
    end

    // Frame sequencing: next state, frame registers and bank hand-back.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        addr_d      = addr_q;
        bank_sel_d  = bank_sel_q;
        gap_d       = gap_q;
        bank_free_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[ptr_q]) begin
                    state_d    = ST_READ;
                    addr_d     = '0;
                    bank_sel_d = ptr_q;
                    if ((frame_len == '0) || (frame_len > MAX_LEN)) begin
                        len_d = MAX_LEN;
                    end else begin
                        len_d = frame_len;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bram_en_s) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (final_addr_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pop_s && tlast_s) begin
                    bank_free_d = ptr_q ? 2'b10 : 2'b01;
                    ptr_d       = ~ptr_q;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            bank_full_q <= 2'b00;
            overflow_q  <= 1'b0;
            bank_free_q <= 2'b00;
            len_q       <= '0;
            addr_q      <= '0;
            bank_sel_q  <= 1'b0;
            gap_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
            bank_free_q <= bank_free_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            bank_sel_q  <= bank_sel_d;
            gap_q       <= gap_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    // busy covers the decision cycle in which a full bank is accepted.
    assign busy          = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    assign bank_free     = bank_free_q;
    assign bram_en       = bram_en_s;
    assign bram_bank_sel = bank_sel_q;
    assign bram_addr     = addr_q;
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tlast  = tlast_s;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_bram_pingpong_scheduler.sv
// Self-checking bench for bram_pingpong_scheduler: a latency-2 BRAM model feeds the DUT and
// observed beats are compared with frames built directly from the bank contents.
module tb_bram_pingpong_scheduler;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   frame_len;
    logic [1:0]    bank_full_set;
    logic [1:0]    bank_free;
    logic          bram_en;
    logic          bram_bank_sel;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          overflow_err;

    bram_pingpong_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .frame_len(frame_len), .bank_full_set(bank_full_set),
        .bank_free(bank_free), .bram_en(bram_en), .bram_bank_sel(bram_bank_sel),
        .bram_addr(bram_addr), .bram_rdata(bram_rdata), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // BRAM model: data valid two cycles after the enable, garbage otherwise.
    logic [DW-1:0] mem [2][32];
    logic          st_v;
    logic [DW-1:0] st_d;
    always @(posedge clk) begin
        st_v       <= bram_en;
        st_d       <= mem[bram_bank_sel][bram_addr];
        bram_rdata <= (st_v === 1'b1) ? st_d : DW'($urandom);
    end

    typedef struct { logic [DW-1:0] data; logic last; int cyc; } beat_t;
    beat_t      beats[$];
    beat_t      exp_q[$];
    int         en_cyc[$];
    int         en_addr[$];
    int         en_bank[$];
    int         free_cyc[$];
    logic [1:0] free_val[$];
    bit         busy_log[int];
    int         cyc = 0, errors = 0, checks = 0;
    int         issued, popped, max_credit, stall_viol, tready_mode, set_cyc;
    logic       prev_stall;
    logic [DW-1:0] prev_data;
    logic       prev_last;

    function automatic int exp_len(input int fl);
        return (fl == 0 || fl > 32) ? 32 : fl;
    endfunction

    task automatic build_exp(input int bank, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back('{mem[bank][i], 1'(i == len - 1), 0});
    endtask

    task automatic clear_logs();
        beats.delete(); exp_q.delete(); en_cyc.delete(); en_addr.delete(); en_bank.delete();
        free_cyc.delete(); free_val.delete();
        issued = 0; popped = 0; max_credit = 0; stall_viol = 0; prev_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        m_axis_tready = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stall_viol++;
        if (bram_en === 1'b1) begin
            issued++;
            en_cyc.push_back(cyc); en_addr.push_back(int'(bram_addr)); en_bank.push_back(int'(bram_bank_sel));
        end
        if (issued - popped > max_credit) max_credit = issued - popped;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            beats.push_back('{m_axis_tdata, m_axis_tlast, cyc});
            popped++;
        end
        if (bank_free !== 2'b00) begin free_cyc.push_back(cyc); free_val.push_back(bank_free); end
        busy_log[cyc] = busy;
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    endtask

    task automatic pulse_set(input logic [1:0] v);
        bank_full_set = v;
        set_cyc = cyc;
        tick();
        bank_full_set = 2'b00;
    endtask

    task automatic run_until_frees(input int n, input int budget);
        int k = 0;
        while (free_cyc.size() < n && k < budget) begin tick(); k++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bank_free, bram_en, bram_bank_sel, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, overflow_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got free=%b en=%b sel=%b addr=%0d data=%h v=%b l=%b busy=%b ovf=%b, expected all zero",
                     bank_free, bram_en, bram_bank_sel, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, overflow_err);
        end
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_basic();
        int t;
        clear_logs(); tready_mode = 0; frame_len = 7'd8;
        pulse_set(2'b01); t = set_cyc;
        repeat (4) tick();
        frame_len = 7'd3;
        run_until_frees(1, 100);
        repeat (4) tick();
        build_exp(0, 8);
        checks++; if (free_cyc.size() != 1) begin errors++; $display("FAIL basic_free_count: got %0d expected 1", free_cyc.size()); end
        if (free_cyc.size() == 1) begin
            checks++; if (free_val[0] !== 2'b01 || free_cyc[0] != t + 13) begin errors++;
                $display("FAIL basic_free: got %b at %0d expected 01 at %0d", free_val[0], free_cyc[0], t + 13); end
        end
        checks++; if (en_cyc.size() != 8) begin errors++; $display("FAIL basic_en_count: got %0d expected 8", en_cyc.size()); end
        for (int i = 0; i < en_cyc.size() && i < 8; i++) begin
            checks++; if (en_cyc[i] != t + 2 + i || en_addr[i] != i || en_bank[i] != 0) begin errors++;
                $display("FAIL basic_read[%0d]: got cyc %0d addr %0d bank %0d expected cyc %0d addr %0d bank 0",
                         i, en_cyc[i], en_addr[i], en_bank[i], t + 2 + i, i); end
        end
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL basic_beat_count: got %0d expected 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last || beats[i].cyc != t + 5 + i) begin
                errors++; $display("FAIL basic_beat[%0d]: got %h/%b at %0d expected %h/%b at %0d", i, beats[i].data,
                                   beats[i].last, beats[i].cyc, exp_q[i].data, exp_q[i].last, t + 5 + i); end
        end
        for (int c = t; c <= t + 15; c++) begin
            checks++; if (busy_log[c] != (c >= t + 1 && c <= t + 14)) begin errors++;
                $display("FAIL basic_busy: got %b at cycle %0d (set at %0d)", busy_log[c], c, t); end
        end
    endtask

    task automatic test_backpressure();
        clear_logs(); tready_mode = 1; frame_len = 7'd8;
        pulse_set(2'b10);
        run_until_frees(1, 300);
        repeat (3) tick();
        tready_mode = 0;
        build_exp(1, 8);
        checks++; if (free_cyc.size() != 1 || free_val[0] !== 2'b10) begin errors++;
            $display("FAIL bp_free: got %0d pulses expected one pulse of 10", free_cyc.size()); end
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL bp_beat_count: got %0d expected 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last) begin errors++;
                $display("FAIL bp_beat[%0d]: got %h/%b expected %h/%b", i, beats[i].data, beats[i].last, exp_q[i].data, exp_q[i].last); end
        end
        checks++; if (max_credit > 4) begin errors++; $display("FAIL bp_credit: got %0d outstanding expected at most 4", max_credit); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes while stalled expected 0", stall_viol); end
    endtask

    task automatic test_back_to_back();
        clear_logs(); frame_len = 7'd32;
        pulse_set(2'b11);
        run_until_frees(2, 400);
        repeat (4) tick();
        build_exp(0, 32); build_exp(1, 32);
        checks++; if (free_cyc.size() != 2) begin errors++; $display("FAIL b2b_free_count: got %0d expected 2", free_cyc.size()); end
        if (free_cyc.size() == 2) begin
            checks++; if (free_val[0] !== 2'b01 || free_val[1] !== 2'b10) begin errors++;
                $display("FAIL b2b_free_order: got %b,%b expected 01,10", free_val[0], free_val[1]); end
        end
        checks++; if (beats.size() != 64) begin errors++; $display("FAIL b2b_beat_count: got %0d expected 64", beats.size()); end
        for (int i = 0; i < beats.size() && i < 64; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last) begin errors++;
                $display("FAIL b2b_beat[%0d]: got %h/%b expected %h/%b", i, beats[i].data, beats[i].last, exp_q[i].data, exp_q[i].last); end
        end
        if (beats.size() == 64) begin
            checks++; if (beats[32].cyc - beats[31].cyc - 1 < 2) begin errors++;
                $display("FAIL b2b_gap: got %0d idle cycles expected at least 2", beats[32].cyc - beats[31].cyc - 1); end
        end
    endtask

    task automatic test_order();
        int fl, len;
        clear_logs();
        fl = $urandom_range(0, 63); len = exp_len(fl); frame_len = 7'(fl);
        pulse_set(2'b10);
        repeat (50) tick();
        checks++; if (en_cyc.size() != 0 || beats.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL order_hold: got %0d reads %0d beats busy=%b expected none", en_cyc.size(), beats.size(), busy); end
        pulse_set(2'b01);
        run_until_frees(2, 400);
        repeat (4) tick();
        build_exp(0, len); build_exp(1, len);
        checks++; if (free_cyc.size() != 2 || free_val[0] !== 2'b01 || free_val[1] !== 2'b10) begin errors++;
            $display("FAIL order_free: got %0d pulses expected 01 then 10", free_cyc.size()); end
        checks++; if (beats.size() != 2 * len) begin errors++;
            $display("FAIL order_beat_count: got %0d expected %0d (frame_len %0d)", beats.size(), 2 * len, fl); end
        for (int i = 0; i < beats.size() && i < 2 * len; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last) begin errors++;
                $display("FAIL order_beat[%0d]: got %h/%b expected %h/%b", i, beats[i].data, beats[i].last, exp_q[i].data, exp_q[i].last); end
        end
    endtask

    task automatic test_overflow();
        clear_logs(); frame_len = 7'd0;
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b expected 0", overflow_err); end
        pulse_set(2'b01);
        repeat (4) tick();
        pulse_set(2'b01);
        tick();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
        run_until_frees(1, 300);
        repeat (20) tick();
        build_exp(0, 32);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
        checks++; if (free_cyc.size() != 1 || en_cyc.size() != 32) begin errors++;
            $display("FAIL ovf_single_frame: got %0d frees %0d reads expected 1 and 32", free_cyc.size(), en_cyc.size()); end
        checks++; if (beats.size() != 32) begin errors++; $display("FAIL ovf_beat_count: got %0d expected 32", beats.size()); end
        for (int i = 0; i < beats.size() && i < 32; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last) begin errors++;
                $display("FAIL ovf_beat[%0d]: got %h/%b expected %h/%b", i, beats[i].data, beats[i].last, exp_q[i].data, exp_q[i].last); end
        end
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        clear_logs(); frame_len = 7'd8;
        pulse_set(2'b10);
        while (beats.size() < 3 && k < 60) begin tick(); k++; end
        checks++; if (beats.size() != 3) begin errors++; $display("FAIL rstmid_reach: got %0d beats expected 3", beats.size()); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b0 || bank_free !== 2'b00) begin errors++;
            $display("FAIL rstmid_outputs: got v=%b en=%b busy=%b free=%b expected 0", m_axis_tvalid, bram_en, busy, bank_free); end
        clear_logs();
        repeat (40) tick();
        checks++; if (en_cyc.size() != 0 || beats.size() != 0 || free_cyc.size() != 0) begin errors++;
            $display("FAIL rstmid_quiet: got %0d reads %0d beats %0d frees expected none", en_cyc.size(), beats.size(), free_cyc.size()); end
        pulse_set(2'b01);
        run_until_frees(1, 200);
        repeat (20) tick();
        build_exp(0, 8);
        checks++; if (free_cyc.size() != 1 || free_val[0] !== 2'b01 || en_cyc.size() != 8) begin errors++;
            $display("FAIL rstmid_restart: got %0d frees %0d reads expected one 01 pulse and 8 reads", free_cyc.size(), en_cyc.size()); end
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL rstmid_beat_count: got %0d expected 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++; if (beats[i].data !== exp_q[i].data || beats[i].last !== exp_q[i].last) begin errors++;
                $display("FAIL rstmid_beat[%0d]: got %h/%b expected %h/%b", i, beats[i].data, beats[i].last, exp_q[i].data, exp_q[i].last); end
        end
    endtask

    initial begin
        rst = 1'b1; bank_full_set = 2'b00; frame_len = '0; m_axis_tready = 1'b1; tready_mode = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++) mem[b][i] = DW'($urandom);
        clear_logs();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_order();
        test_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
